uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, 7/8 data bits, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on ticks 7, 8 and 9 of each bit.
module uart_receiver #(
  parameter int DIV0 = 326,
  parameter int DIV1 = 163,
  parameter int DIV2 = 54,
  parameter int DIV3 = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rxd,
  input  logic       dnum,
  input  logic       snum,
  input  logic [1:0] par,
  input  logic [1:0] bd_rate,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int CW = 16;

  // Tick on which a bit is decided: START counts from the falling edge,
  // later bits count 16 ticks from the previous decision.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [4:0] START_LAST = 5'd9;
`else
  localparam logic [4:0] START_LAST = 5'd8;
`endif
  localparam logic [4:0] BIT_LAST = 5'd16;

  state_t state, state_nxt;

  logic          rx_meta, rx_s;
  logic [CW-1:0] div_sel, div_l, div_cnt;
  logic [4:0]    tick_cnt, tick_nxt, last_tick;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, d_final;
  logic          dnum_l, snum_l;
  logic [1:0]    par_l;
  logic          pbit, stop_err;
  logic          tick, decide, bit_val;
  logic          par_en, last_data, last_stop;
  logic          start_go, frame_done, perr_calc;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the pre-edge value of its source.
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    case (bd_rate)
      2'b00:   div_sel = CW'(DIV0);
      2'b01:   div_sel = CW'(DIV1);
      2'b10:   div_sel = CW'(DIV2);
      default: div_sel = CW'(DIV3);
    endcase
  end

  assign tick      = en && (state != IDLE) && (div_cnt == div_l - CW'(1));
  assign tick_nxt  = tick_cnt + 5'd1;
  assign last_tick = (state == START) ? START_LAST : BIT_LAST;
  assign decide    = tick && (tick_nxt == last_tick);

`ifdef UART_RX_MAJORITY_EN
  logic vote_a, vote_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (tick) begin
      if (tick_nxt == last_tick - 5'd2) vote_a <= rx_s;
      if (tick_nxt == last_tick - 5'd1) vote_b <= rx_s;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign par_en     = (par_l == 2'b01) || (par_l == 2'b10);
  assign last_data  = (bit_cnt == (dnum_l ? 3'd7 : 3'd6));
  assign last_stop  = !snum_l || bit_cnt[0];
  assign start_go   = (state == IDLE) && en && !rx_s;
  assign frame_done = (state == STOP) && decide && last_stop;

  // In 7-bit mode the first bit has only been shifted down to position 1.
  assign d_final = dnum_l ? shreg : {1'b0, shreg[7:1]};

  always_comb begin
    case (par_l)
      2'b01:   perr_calc = pbit ^ (^d_final);
      2'b10:   perr_calc = pbit ^ ~(^d_final);
      default: perr_calc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:   if (start_go) state_nxt = START;
      START:  if (decide) state_nxt = bit_val ? IDLE : DATA;
      DATA:   if (decide && last_data) state_nxt = par_en ? PARITY : STOP;
      PARITY: if (decide) state_nxt = STOP;
      STOP:   if (decide && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  // Frame configuration is captured at the start edge and held for the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_l  <= CW'(DIV0);
      dnum_l <= 1'b1;
      snum_l <= 1'b0;
      par_l  <= 2'b00;
    end else if (start_go) begin
      div_l  <= div_sel;
      dnum_l <= dnum;
      snum_l <= snum;
      par_l  <= par;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pbit     <= 1'b0;
      stop_err <= 1'b0;
    end else if (state == IDLE || !en) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_err <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      if (tick) tick_cnt <= decide ? 5'd0 : tick_nxt;
      if (decide) begin
        case (state)
          START: bit_cnt <= '0;
          DATA: begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_cnt <= last_data ? 3'd0 : bit_cnt + 3'd1;
          end
          PARITY: pbit <= bit_val;
          STOP: begin
            stop_err <= stop_err | !bit_val;
            bit_cnt  <= bit_cnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs change only on a completed frame and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 8'h00;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= frame_done;
      if (frame_done) begin
        data       <= d_final;
        parity_err <= perr_calc;
        frame_err  <= stop_err | !bit_val;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
